uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10416, clock cycles per serial bit (100 MHz clock, 9600 baud); legal range 2..65535.
REQ-002 Port clk_i  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port nreset_i  input  1  reset; one clock, reset is synchronous and active-low.
REQ-004 Port valid_i  input  1  upstream asserts that data_i holds a byte to send.
REQ-005 Port data_i  input  8  byte to transmit, sampled only on an accepting edge.
REQ-006 Port ready_o  output  1  block can accept a byte this cycle.
REQ-007 Port tx_o  output  1  serial line output, idle-high, driven from a register.
REQ-008 Port busy_o  output  1  a frame is in progress (state other than IDLE).

Function
REQ-009 The FSM SHALL have states IDLE, START, DATA, PARITY (exists only with the macro), STOP.
REQ-010 Handshake: a byte is accepted on a rising edge where valid_i=1 and ready_o=1; ready_o=1 only in IDLE.
REQ-011 On acceptance, data_i SHALL be latched into an 8-bit shift register; later data_i changes have no effect on the frame.
REQ-012 Latency: tx_o SHALL go low (start bit) in the cycle immediately after the accepting edge; ready_o and busy_o change in that same cycle.
REQ-013 Each of start, data, parity and stop bits SHALL hold tx_o for exactly CLKS_PER_BIT cycles, timed by a bit counter of width clog2(CLKS_PER_BIT) counting 0..CLKS_PER_BIT-1.
REQ-014 Transitions: IDLE->START on acceptance; START->DATA at counter terminal count; DATA->DATA for bits 0..6; DATA->PARITY (macro) or STOP after bit 7; PARITY->STOP; STOP->IDLE at terminal count.
REQ-015 Data bits SHALL be sent LSB first; a 3-bit index counts 0..7 and SHALL NOT wrap within a frame.
REQ-016 Stop bit SHALL be a single logic 1.
REQ-017 After STOP, the block SHALL spend at least one cycle in IDLE (tx_o=1, ready_o=1) before the next start bit; with valid_i held high, the next start bit begins on the cycle after that IDLE cycle.
REQ-018 valid_i asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-019 valid_i deasserting mid-frame SHALL NOT abort the frame.
REQ-020 tx_o SHALL be glitch-free: it changes only on bit boundaries.

Reset
REQ-021 While nreset_i=0 at a rising edge: state=IDLE, tx_o=1, ready_o=1 in the following cycle, busy_o=0, bit counter=0, bit index=0, shift register=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame; tx_o returns high on the edge the reset is sampled, and no partial bits resume after release.
REQ-023 The first acceptance after reset release SHALL be possible on the first edge where nreset_i=1 and valid_i=1.

Configuration
REQ-024 Macro UART_TX_PARITY_EN: when defined, an even-parity bit (XOR of the 8 latched data bits) SHALL be sent between bit 7 and stop, so the frame is 11 bits.
REQ-025 Without UART_TX_PARITY_EN: PARITY state and parity logic SHALL be absent, and the frame is 10 bits (10*CLKS_PER_BIT cycles from start to the end of stop).

Verification
REQ-026 Reset check: nreset_i=0 for 5 cycles with valid_i=1 -> tx_o=1, ready_o=1, busy_o=0 throughout, and no start bit.
REQ-027 Single byte: CLKS_PER_BIT=16, send 8'h81 -> tx_o sequence 0,1,0,0,0,0,0,0,1,1, each bit 16 cycles; ready_o low for exactly 160 cycles.
REQ-028 Back-to-back: valid_i held with 8'h80 then 8'h00 -> two frames separated by exactly one idle-high cycle; second frame carries 0x00.
REQ-029 Ignore while busy: pulse valid_i with 8'hF1 mid-frame of 8'h55 -> only 0x55 is transmitted, and tx_o stays high after it.
REQ-030 Mid-frame reset: assert nreset_i=0 during data bit 3 of 8'hA5 -> tx_o=1 next cycle; after release, a new 8'h3C frame is correct.
REQ-031 Parity (UART_TX_PARITY_EN defined): send 8'hF1 -> parity bit 1; send 8'h81 -> parity bit 0; frame length 176 cycles at CLKS_PER_BIT=16.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, one stop bit, valid/ready byte handshake.
// Optional even-parity bit between bit 7 and stop when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 10416
) (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               tick;
`ifdef UART_TX_PARITY_EN
  logic               par_q, par_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tick = (cnt_q == CNT_LAST);

  // Next state; outputs are derived from the next state so they register with it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (valid_i) begin
          state_d = START;
          shift_d = data_i;
`ifdef UART_TX_PARITY_EN
          par_d   = ^data_i;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d = '0;
          if (idx_q == IDX_W'(7)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  assign ready_o = ready_q;
  assign tx_o    = tx_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=16; table of frames plus reset,
// back-to-back, busy-ignore and mid-frame reset sequences.
module tb_uart_tx;

  localparam int unsigned CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, tx, busy;

  int passed = 0;
  int total  = 0;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i    (clk),
    .nreset_i (nreset),
    .valid_i  (valid),
    .data_i   (data),
    .ready_o  (ready),
    .tx_o     (tx),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  // seq: serial levels in time order, MSB first = start bit ... last = stop bit
  typedef struct {
    logic [7:0] data;
    logic [9:0] seq;
    logic       par;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_bit(input logic [9:0] seq, input logic par, input int i);
`ifdef UART_TX_PARITY_EN
    if (i < 9) return seq[9-i];
    else if (i == 9) return par;
    else return seq[0];
`else
    return seq[9-i];
`endif
  endfunction

  // Called in the first start-bit cycle; returns in the IDLE cycle after stop
  task automatic check_frame(input logic [9:0] seq, input logic par, input int pulse_at,
                             input string name);
    int low = 0;
    for (int b = 0; b < int'(NB); b++) begin
      int bad = 0;
      for (int c = 0; c < int'(CPB); c++) begin
        int cyc = b * int'(CPB) + c;
        if (tx !== exp_bit(seq, par, b) || busy !== 1'b1) bad++;
        if (ready === 1'b0) low++;
        if (cyc == pulse_at) begin
          valid = 1'b1;
          data  = 8'hF1;
        end else if (pulse_at >= 0 && cyc == pulse_at + 1) begin
          valid = 1'b0;
        end
        tick();
      end
      check($sformatf("%s bit%0d bad cycles", name, b), 32'(bad), 32'd0);
    end
    check($sformatf("%s ready-low cycles", name), 32'(low), 32'(NB * CPB));
    check($sformatf("%s idle {tx,ready,busy}", name), {29'd0, tx, ready, busy}, 32'b110);
  endtask

  task automatic accept(input logic [7:0] d);
    valid = 1'b1;
    data  = d;
    tick();
    valid = 1'b0;
    data  = ~d;
  endtask

  initial begin
    vecs[0] = '{8'h81, 10'b0100000011, 1'b0};
    vecs[1] = '{8'h55, 10'b0101010101, 1'b0};
    vecs[2] = '{8'hF1, 10'b0100011111, 1'b1};
    vecs[3] = '{8'h00, 10'b0000000001, 1'b0};
    vecs[4] = '{8'hA5, 10'b0101001011, 1'b0};
    vecs[5] = '{8'h3C, 10'b0001111001, 1'b0};
    vecs[6] = '{8'hFF, 10'b0111111111, 1'b0};
    vecs[7] = '{8'h80, 10'b0000000011, 1'b1};

    // Reset held with valid high: line idle, nothing starts
    nreset = 1'b0;
    valid  = 1'b1;
    data   = 8'h81;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("reset cycle%0d {tx,ready,busy}", i), {29'd0, tx, ready, busy}, 32'b110);
    end
    // First edge out of reset with valid high accepts
    nreset = 1'b1;
    tick();
    valid = 1'b0;
    data  = 8'h7E;
    check_frame(vecs[0].seq, vecs[0].par, -1, "post-reset 81");

    for (int v = 0; v < 8; v++) begin
      accept(vecs[v].data);
      check_frame(vecs[v].seq, vecs[v].par, -1, $sformatf("table %02h", vecs[v].data));
    end

    // Back-to-back with valid held: exactly one idle cycle between frames
    valid = 1'b1;
    data  = 8'h80;
    tick();
    data  = 8'h00;
    check_frame(vecs[7].seq, vecs[7].par, -1, "b2b first 80");
    tick();
    valid = 1'b0;
    check_frame(vecs[3].seq, vecs[3].par, -1, "b2b second 00");

    // valid pulse while busy is dropped, not queued
    accept(8'h55);
    check_frame(vecs[1].seq, vecs[1].par, 50, "busy-ignore 55");
    begin
      int lows = 0;
      for (int i = 0; i < 40; i++) begin
        if (tx !== 1'b1 || ready !== 1'b1) lows++;
        tick();
      end
      check("busy-ignore no queued frame", 32'(lows), 32'd0);
    end

    // Reset during data bit 3 of A5 aborts the frame
    accept(8'hA5);
    repeat (72) tick();
    check("A5 data bit3 level", {31'd0, tx}, 32'd0);
    nreset = 1'b0;
    tick();
    check("mid-frame reset {tx,ready,busy}", {29'd0, tx, ready, busy}, 32'b110);
    tick();
    nreset = 1'b1;
    begin
      int lows = 0;
      for (int i = 0; i < 3 * int'(CPB); i++) begin
        tick();
        if (tx !== 1'b1 || busy !== 1'b0) lows++;
      end
      check("no resume after reset", 32'(lows), 32'd0);
    end
    accept(8'h3C);
    check_frame(vecs[5].seq, vecs[5].par, -1, "after reset 3C");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
